sram_read_scheduler: RTL
========================

SRAM_READ_SCHEDULER -- requirements
Module: sram_read_scheduler

Interface
REQ-001 clk  in  1  single clock; all logic posedge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 rd_req  in  16  bit i = output port i requests one packet read from this SRAM; level, held until rd_grant[i].
REQ-004 rd_req_head  in  176  port i head page at bits [11i+10:11i].
REQ-005 rd_req_tail  in  176  port i tail page, same packing.
REQ-006 rd_grant  out  16  one-hot, one-cycle pulse accepting port i request.
REQ-007 rd_page_down  out  1  page-start strobe to the SRAM interface.
REQ-008 rd_page  out  11  page under read; held stable for the whole 8-cycle page.
REQ-009 rd_next_page  in  16  {sram_idx[4:0], page[10:0]} from the jump table; page field used.
REQ-010 rd_xfer_data  in  16  half-word from the SRAM interface.
REQ-011 out_port  out  4  port owning out_data.
REQ-012 out_data_vld  out  1  out_data valid.
REQ-013 out_data  out  16  forwarded rd_xfer_data.
REQ-014 out_end_of_packet  out  1  with last half-word of tail page.
REQ-015 out_error  out  1  one-cycle pulse on runaway-chain abort.
REQ-016 busy  out  1  high whenever state != IDLE or data still draining.

Function
REQ-017 States: IDLE, READ; page batch counter bcnt 0..7; page counter pcnt 0..63.
REQ-018 IDLE: if rd_req != 0, round-robin pick starting at pointer rr; pulse rd_grant, latch port/head/tail, rr <= granted+1 (mod 16), enter READ.
REQ-019 First READ cycle (grant+1): rd_page_down=1, rd_page=head, bcnt=0.
REQ-020 Each page occupies exactly 8 cycles T..T+7; bcnt increments per cycle.
REQ-021 At bcnt==7 (T+7): if rd_page==tail, go IDLE; else rd_page <= rd_next_page[10:0], issue rd_page_down at T+8 (back-to-back pages, no bubble).
REQ-022 Read data latency 1: out_data_vld high T+1..T+8 per page; out_port constant per packet; out_data = rd_xfer_data combinationally registered-free passthrough, vld/port/eop delayed 1 cycle.
REQ-023 out_end_of_packet high only with batch-7 data of the tail page.
REQ-024 Next arbitration earliest at T+8 of last page; next rd_page_down at T+9 (one-cycle bubble between packets).
REQ-025 Runaway: pcnt reaches 64 pages without tail -> out_error pulse with final half-word, out_end_of_packet also asserted, return IDLE.
REQ-026 Request deasserted before grant: not granted, no side effect; rd_req changes after grant ignored.
REQ-027 Head==tail: single-page packet, exactly 8 valid half-words.
REQ-028 Grant never issued while READ active; at most one packet in flight.

Reset
REQ-029 rst_n low (any time, including mid-page): state IDLE, rr=0, bcnt=0, pcnt=0; all outputs 0; in-flight packet discarded, no eop emitted.
REQ-030 First grant possible the first clock edge after rst_n deasserts.

Configuration
REQ-031 SRAM_RD_SCHED_ECC_EN defined: add input rd_ecc_code (8) and outputs out_ecc_code (8), out_ecc_vld (1); rd_ecc_code sampled at T+2, presented with out_ecc_vld pulse aligned to batch-7 data (T+8) of every page; reset 0.
REQ-032 Macro undefined: those ports and logic absent; all other behaviour identical.

Structure
REQ-033 Shared package sram_pkg: PAGE_W=11, NUM_PORTS=16, PAGE_BATCHES=8, MAX_PKT_PAGES=64, state enum.
REQ-034 One sub-module rr_arbiter_16 (request vector, pointer -> one-hot grant).

Verification
REQ-035 Port 3 head=5 tail=5 -> grant[3] one cycle, page_down at +1 rd_page=5, 8 vld beats, eop on 8th, busy drops.
REQ-036 Port 0 chain 10->20->30 tail=30 -> page_down every 8 cycles, rd_page 10,20,30, 24 beats, single eop.
REQ-037 Ports 2,7,15 request together, rr=0 -> grants in order 2,7,15; each new page_down 1 cycle after previous packet's final page window.
REQ-038 Chain never hits tail -> 64 pages (512 beats), out_error and eop on beat 512, IDLE.
REQ-039 rst_n low at bcnt=4 -> outputs 0 immediately, no eop; new request after release served from head.
REQ-040 ECC_EN build, rd_ecc_code=8'hA5 at T+2 -> out_ecc_code=8'hA5, out_ecc_vld at T+8.

Source files
------------

// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared constants and types for the SRAM read scheduler.
//   PAGE_W        page address width
//   NUM_PORTS     number of requesting output ports
//   PAGE_BATCHES  half-word beats per page (one beat per cycle)
//   MAX_PKT_PAGES page count after which a chain without a tail is aborted
//   state_t       scheduler FSM state (IDLE / READ)
// ----------------------------------------------------------------------------
package sram_pkg;

    localparam int PAGE_W        = 11;
    localparam int NUM_PORTS     = 16;
    localparam int PORT_W        = 4;
    localparam int PAGE_BATCHES  = 8;
    localparam int BCNT_W        = 3;
    localparam int MAX_PKT_PAGES = 64;
    localparam int PCNT_W        = 6;
    localparam int DATA_W        = 16;
    localparam int ECC_W         = 8;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/sram_read_scheduler_if.sv
// ----------------------------------------------------------------------------
// sram_read_scheduler_if
// Request/grant bundle between the output ports and the read scheduler.
//   rd_req       [NUM_PORTS]          per-port request level
//   rd_req_head  [NUM_PORTS*PAGE_W]   port i head page at [11i+10:11i]
//   rd_req_tail  [NUM_PORTS*PAGE_W]   port i tail page, same packing
//   rd_grant     [NUM_PORTS]          one-hot single-cycle grant
// Handshake: a port raises rd_req[i] with head/tail stable and holds it until
// it sees rd_grant[i] high for one cycle; the request is consumed on that
// clock edge, so the port must drop rd_req[i] afterwards.
// Modports: master = requesting ports, slave = scheduler.
// ----------------------------------------------------------------------------
interface sram_read_scheduler_if;
    import sram_pkg::*;

    logic [NUM_PORTS-1:0]        rd_req;
    logic [NUM_PORTS*PAGE_W-1:0] rd_req_head;
    logic [NUM_PORTS*PAGE_W-1:0] rd_req_tail;
    logic [NUM_PORTS-1:0]        rd_grant;

    modport master (
        output rd_req,
        output rd_req_head,
        output rd_req_tail,
        input  rd_grant
    );

    modport slave (
        input  rd_req,
        input  rd_req_head,
        input  rd_req_tail,
        output rd_grant
    );

endinterface

// File: rtl/rr_arbiter_16.sv
// ----------------------------------------------------------------------------
// rr_arbiter_16
// Combinational round-robin pick over 16 requesters.
//   req        request vector
//   ptr        highest-priority index for this pick
//   grant      one-hot winner (all zero when req is zero)
//   grant_idx  binary index of the winner (0 when req is zero)
// ----------------------------------------------------------------------------
module rr_arbiter_16
    import sram_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PORT_W-1:0]    grant_idx
);

    logic              found;
    logic [PORT_W-1:0] idx;

    // Walk from ptr upwards; the 4-bit index wraps naturally modulo 16.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = ptr + PORT_W'(i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sram_read_scheduler.sv
// ----------------------------------------------------------------------------
// sram_read_scheduler
// Arbitrates packet-read requests from 16 output ports for one SRAM and walks
// the packet's page chain, 8 beats per page, forwarding the read data.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_if (slave)      rd_req / rd_req_head / rd_req_tail / rd_grant
//   rd_page_down        page-start strobe to the SRAM interface
//   rd_page             page under read, stable for the whole page
//   rd_next_page        {sram_idx, page} from the jump table (page used)
//   rd_xfer_data        half-word from the SRAM interface (latency 1)
//   out_port            port owning out_data
//   out_data_vld        out_data valid
//   out_data            rd_xfer_data forwarded (zero when not valid)
//   out_end_of_packet   last half-word of the packet
//   out_error           pulse with the last half-word of an aborted chain
//   busy                reading, or data still draining
//   dbg_state           current FSM state
// Optional build SRAM_RD_SCHED_ECC_EN adds:
//   rd_ecc_code         per-page ECC code, sampled in the third page cycle
//   out_ecc_code        ECC code presented with the page's last beat
//   out_ecc_vld         pulse aligned with the page's last beat
// ----------------------------------------------------------------------------
module sram_read_scheduler
    import sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    sram_read_scheduler_if.slave  req_if,
    output logic                  rd_page_down,
    output logic [PAGE_W-1:0]     rd_page,
    input  logic [15:0]           rd_next_page,
    input  logic [DATA_W-1:0]     rd_xfer_data,
    output logic [PORT_W-1:0]     out_port,
    output logic                  out_data_vld,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_end_of_packet,
    output logic                  out_error,
    output logic                  busy,
    output state_t                dbg_state
`ifdef SRAM_RD_SCHED_ECC_EN
    ,
    input  logic [ECC_W-1:0]      rd_ecc_code,
    output logic [ECC_W-1:0]      out_ecc_code,
    output logic                  out_ecc_vld
`endif
);

    state_t               state_q, state_d;
    logic [PORT_W-1:0]    rr_q, port_q, arb_idx;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [PAGE_W-1:0]    page_q, tail_q, grant_head, grant_tail;
    logic [BCNT_W-1:0]    bcnt_q;
    logic [PCNT_W-1:0]    pcnt_q;
    logic                 grant_en, page_end, at_tail, runaway, pkt_done;
    logic                 vld_q, eop_q, err_q;
    logic [PORT_W-1:0]    out_port_q;
    logic                 unused_sram_idx;

    assign unused_sram_idx = ^rd_next_page[15:PAGE_W];

    rr_arbiter_16 u_arb (
        .req       (req_if.rd_req),
        .ptr       (rr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign grant_head = req_if.rd_req_head[int'(arb_idx)*PAGE_W +: PAGE_W];
    assign grant_tail = req_if.rd_req_tail[int'(arb_idx)*PAGE_W +: PAGE_W];

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        page_end = (state_q == READ) && (bcnt_q == BCNT_W'(PAGE_BATCHES - 1));
        at_tail  = (page_q == tail_q);
        // The 64th page without reaching the tail ends the packet with an error.
        runaway  = page_end && !at_tail && (pcnt_q == PCNT_W'(MAX_PKT_PAGES - 1));
        pkt_done = page_end && (at_tail || runaway);
        case (state_q)
            IDLE: begin
                // rst_n gating keeps rd_grant low while reset is held.
                if (rst_n && (req_if.rd_req != '0)) begin
                    grant_en = 1'b1;
                    state_d  = READ;
                end
            end
            READ: begin
                if (pkt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            port_q  <= '0;
            page_q  <= '0;
            tail_q  <= '0;
            bcnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                rr_q   <= arb_idx + 1'b1;
                port_q <= arb_idx;
                page_q <= grant_head;
                tail_q <= grant_tail;
                bcnt_q <= '0;
                pcnt_q <= '0;
            end else if (state_q == READ) begin
                // bcnt wraps 7 -> 0, so the next page starts without a bubble.
                bcnt_q <= bcnt_q + 1'b1;
                if (page_end && !pkt_done) begin
                    page_q <= rd_next_page[PAGE_W-1:0];
                    pcnt_q <= pcnt_q + 1'b1;
                end
            end
        end
    end

    // Read data arrives one cycle after each READ cycle; qualifiers follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
            out_port_q <= '0;
        end else begin
            vld_q <= (state_q == READ);
            eop_q <= pkt_done;
            err_q <= runaway;
            if (state_q == READ) begin
                out_port_q <= port_q;
            end
        end
    end

`ifdef SRAM_RD_SCHED_ECC_EN
    logic [ECC_W-1:0] ecc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecc_q        <= '0;
            out_ecc_code <= '0;
            out_ecc_vld  <= 1'b0;
        end else begin
            if ((state_q == READ) && (bcnt_q == BCNT_W'(2))) begin
                ecc_q <= rd_ecc_code;
            end
            out_ecc_vld <= page_end;
            if (page_end) begin
                out_ecc_code <= ecc_q;
            end
        end
    end
`endif

    assign req_if.rd_grant   = grant_en ? arb_grant : '0;
    assign rd_page_down      = (state_q == READ) && (bcnt_q == '0);
    assign rd_page           = page_q;
    assign out_port          = out_port_q;
    assign out_data_vld      = vld_q;
    assign out_data          = vld_q ? rd_xfer_data : '0;
    assign out_end_of_packet = eop_q;
    assign out_error         = err_q;
    assign busy              = (state_q != IDLE) || vld_q;
    assign dbg_state         = state_q;

endmodule
